// File: rtl/qu_rob.sv
// qu_rob: in-order-commit reorder buffer for the Qu out-of-order core.
// A mispredicted branch flushes the whole buffer when it commits.
package qu_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_ADDR_WIDTH = 3;

  typedef logic [31:0] dest_t;

  typedef enum logic [1:0] {
    ROB_EMPTY   = 2'd0,
    ROB_PENDING = 2'd1,
    ROB_EXECUTE = 2'd2,
    ROB_RETIRED = 2'd3
  } rob_state_e;

  typedef struct packed {
    rob_state_e  state;
    logic [31:0] value;
    dest_t       dest;
    logic [6:0]  phyreg_old;
    logic        load;
    logic        store;
    logic [2:0]  ldst_funct3;
    logic        mispredicted_branch;
    logic [11:0] pc_new;
  } rob_cell_t;
endpackage

module qu_rob
  import qu_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int AW    = ROB_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  output logic [AW-1:0] alloc_addr,
  input  logic [6:0]    alloc_phyreg_old,
  input  dest_t         alloc_dest,
  input  logic          alloc_load,
  input  logic          alloc_store,
  input  logic [2:0]    alloc_ldst_funct3,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_value,
  input  logic [31:0]   wb_dest,
  input  logic          wb_mispredicted,
  input  logic [11:0]   wb_pc_new,
  output logic          commit_valid,
  input  logic          commit_ready,
  output logic [31:0]   commit_value,
  output logic [31:0]   commit_dest,
  output logic [6:0]    commit_phyreg_old,
  output logic          commit_load,
  output logic          commit_store,
  output logic [2:0]    commit_ldst_funct3,
  output logic [AW-1:0] commit_addr,
  output logic          flush,
  output logic [11:0]   flush_pc,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  rob_cell_t     cells_q [DEPTH];
  rob_cell_t     cells_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          flush_q, flush_d;
  logic [11:0]   flush_pc_q, flush_pc_d;

  logic      alloc_fire;
  logic      commit_fire;
  logic      flush_fire;
  rob_cell_t head_cell;

  assign head_cell   = cells_q[head_q];
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_addr  = tail_q;

  assign commit_valid       = (head_cell.state == ROB_RETIRED);
  assign commit_value       = head_cell.value;
  assign commit_dest        = head_cell.dest;
  assign commit_phyreg_old  = head_cell.phyreg_old;
  assign commit_load        = head_cell.load;
  assign commit_store       = head_cell.store;
  assign commit_ldst_funct3 = head_cell.ldst_funct3;
  assign commit_addr        = head_q;

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && commit_ready;
  assign flush_fire  = commit_fire && head_cell.mispredicted_branch;

  // issue/wb qualify on the pre-edge state, so an entry
  // being allocated this cycle cannot also be written back
  always_comb begin
    cells_d = cells_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_fire && tail_q == AW'(i)) begin
        cells_d[i].state               = ROB_PENDING;
        cells_d[i].value               = '0;
        cells_d[i].dest                = alloc_dest;
        cells_d[i].phyreg_old          = alloc_phyreg_old;
        cells_d[i].load                = alloc_load;
        cells_d[i].store               = alloc_store;
        cells_d[i].ldst_funct3         = alloc_ldst_funct3;
        cells_d[i].mispredicted_branch = 1'b0;
        cells_d[i].pc_new              = '0;
      end
      if (issue_valid && issue_addr == AW'(i)
          && cells_q[i].state == ROB_PENDING) begin
        cells_d[i].state = ROB_EXECUTE;
      end
      if (wb_valid && wb_addr == AW'(i)
          && (cells_q[i].state == ROB_PENDING
              || cells_q[i].state == ROB_EXECUTE)) begin
        cells_d[i].state               = ROB_RETIRED;
        cells_d[i].value               = wb_value;
        cells_d[i].mispredicted_branch = wb_mispredicted;
        cells_d[i].pc_new              = wb_pc_new;
        if (cells_q[i].store) begin
          cells_d[i].dest = wb_dest;
        end
      end
      if (commit_fire && head_q == AW'(i)) begin
        cells_d[i].state = ROB_EMPTY;
      end
      if (flush_fire) begin
        cells_d[i] = '0;
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = 1'b0;
    flush_pc_d = '0;
    if (flush_fire) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = head_cell.pc_new;
    end else begin
      if (alloc_fire) begin
        tail_d = tail_q + 1'b1;
      end
      if (commit_fire) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(alloc_fire)
                - (AW+1)'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cells_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        cells_q[i] <= cells_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

endmodule

// File: tb/tb_qu_rob.sv
// tb_qu_rob: randomized scoreboard bench for qu_rob.
// A queue-of-instructions model predicts commits, flushes and occupancy.
module tb_qu_rob;
  import qu_pkg::*;

  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [AW-1:0] alloc_addr;
  logic [6:0]    alloc_phyreg_old = '0;
  logic [31:0]   alloc_dest = '0;
  logic          alloc_load = 1'b0;
  logic          alloc_store = 1'b0;
  logic [2:0]    alloc_ldst_funct3 = '0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_addr = '0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [31:0]   wb_value = '0;
  logic [31:0]   wb_dest = '0;
  logic          wb_mispredicted = 1'b0;
  logic [11:0]   wb_pc_new = '0;
  logic          commit_valid;
  logic          commit_ready = 1'b0;
  logic [31:0]   commit_value;
  logic [31:0]   commit_dest;
  logic [6:0]    commit_phyreg_old;
  logic          commit_load;
  logic          commit_store;
  logic [2:0]    commit_ldst_funct3;
  logic [AW-1:0] commit_addr;
  logic          flush;
  logic [11:0]   flush_pc;
  logic          empty;
  logic          full;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  qu_rob dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_addr(alloc_addr), .alloc_phyreg_old(alloc_phyreg_old),
    .alloc_dest(alloc_dest), .alloc_load(alloc_load),
    .alloc_store(alloc_store), .alloc_ldst_funct3(alloc_ldst_funct3),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_value(wb_value),
    .wb_dest(wb_dest), .wb_mispredicted(wb_mispredicted),
    .wb_pc_new(wb_pc_new),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_value(commit_value), .commit_dest(commit_dest),
    .commit_phyreg_old(commit_phyreg_old),
    .commit_load(commit_load), .commit_store(commit_store),
    .commit_ldst_funct3(commit_ldst_funct3),
    .commit_addr(commit_addr),
    .flush(flush), .flush_pc(flush_pc),
    .empty(empty), .full(full), .count(count)
  );

  typedef struct {
    int          addr;
    logic [6:0]  pold;
    logic [31:0] dest;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] val;
    logic        mis;
    logic [11:0] pc;
    bit          done;
  } ent_t;

  typedef struct {
    int          cnt;
    int          tl;
    int          hd;
    bit          cv;
    bit          fl;
    logic [11:0] fpc;
  } st_t;

  ent_t rob_m[$];
  ent_t exp_q[$];
  st_t  st_q[$];
  int          tl_m = 0;
  bit          fl_m = 1'b0;
  logic [11:0] fpc_m = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic rst_chk(string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_alloc_ready"}, 32'(alloc_ready), 1);
    chk({tag, "_alloc_addr"}, 32'(alloc_addr), 0);
    chk({tag, "_commit_valid"}, 32'(commit_valid), 0);
    chk({tag, "_commit_addr"}, 32'(commit_addr), 0);
    chk({tag, "_commit_value"}, commit_value, 0);
    chk({tag, "_commit_dest"}, commit_dest, 0);
    chk({tag, "_commit_pold"}, 32'(commit_phyreg_old), 0);
    chk({tag, "_flush"}, 32'(flush), 0);
    chk({tag, "_flush_pc"}, 32'(flush_pc), 0);
  endtask

  // one clock of stimulus; the model advances to the post-edge view
  task automatic cycle(int pa, int pw, int pcr, int pmis, int wsel);
    st_t  s;
    ent_t e;
    bit   af, cf, fl_now;
    int   k;
    @(negedge clk);
    s.cnt = rob_m.size();
    s.tl  = tl_m;
    s.hd  = (rob_m.size() > 0) ? rob_m[0].addr : tl_m;
    s.cv  = (rob_m.size() > 0) && rob_m[0].done;
    s.fl  = fl_m;
    s.fpc = fpc_m;
    st_q.push_back(s);

    alloc_valid       = ($urandom_range(99) < pa);
    alloc_phyreg_old  = 7'($urandom);
    alloc_dest        = $urandom;
    alloc_load        = 1'($urandom);
    alloc_store       = 1'($urandom);
    alloc_ldst_funct3 = 3'($urandom);
    issue_valid       = 1'($urandom);
    issue_addr        = AW'($urandom);
    wb_valid          = ($urandom_range(99) < pw);
    wb_addr           = AW'($urandom);
    if (rob_m.size() > 0 && $urandom_range(99) < 75) begin
      k = $urandom_range(rob_m.size() - 1);
      wb_addr = AW'(rob_m[k].addr);
    end
    if (wsel >= 0) begin
      wb_valid = 1'b1;
      wb_addr  = AW'(wsel);
    end
    wb_value        = $urandom;
    wb_dest         = $urandom;
    wb_mispredicted = ($urandom_range(99) < pmis);
    wb_pc_new       = 12'($urandom);
    commit_ready    = ($urandom_range(99) < pcr);

    af     = alloc_valid && (rob_m.size() < D);
    cf     = s.cv && commit_ready;
    fl_now = cf && rob_m[0].mis;
    fl_m   = fl_now;
    fpc_m  = fl_now ? rob_m[0].pc : '0;
    if (cf) exp_q.push_back(rob_m[0]);

    if (wb_valid) begin
      foreach (rob_m[i]) begin
        if (rob_m[i].addr == int'(wb_addr) && !rob_m[i].done) begin
          rob_m[i].done = 1'b1;
          rob_m[i].val  = wb_value;
          rob_m[i].mis  = wb_mispredicted;
          rob_m[i].pc   = wb_pc_new;
          if (rob_m[i].st) rob_m[i].dest = wb_dest;
        end
      end
    end

    if (fl_now) begin
      rob_m.delete();
      tl_m = 0;
    end else begin
      if (cf) void'(rob_m.pop_front());
      if (af) begin
        e.addr = tl_m;
        e.pold = alloc_phyreg_old;
        e.dest = alloc_dest;
        e.ld   = alloc_load;
        e.st   = alloc_store;
        e.f3   = alloc_ldst_funct3;
        e.val  = '0;
        e.mis  = 1'b0;
        e.pc   = '0;
        e.done = 1'b0;
        rob_m.push_back(e);
        tl_m = (tl_m + 1) % D;
      end
    end
  endtask

  task automatic rst_mid();
    cycle(0, 0, 0, 0, -1);
    #3;
    rst_n = 1'b0;
    #1;
    rst_chk("mid_reset");
    rst_n = 1'b1;
    rob_m.delete();
    exp_q.delete();
    tl_m  = 0;
    fl_m  = 1'b0;
    fpc_m = '0;
  endtask

  // monitor: compare the DUT view against what the driver predicted
  initial begin
    st_t  s;
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("count", 32'(count), 32'(s.cnt));
        chk("empty", 32'(empty), 32'(s.cnt == 0));
        chk("full", 32'(full), 32'(s.cnt == D));
        chk("alloc_ready", 32'(alloc_ready), 32'(s.cnt != D));
        chk("alloc_addr", 32'(alloc_addr), 32'(s.tl));
        chk("commit_valid", 32'(commit_valid), 32'(s.cv));
        chk("flush", 32'(flush), 32'(s.fl));
        if (s.fl) chk("flush_pc", 32'(flush_pc), 32'(s.fpc));
        if (s.cv) chk("commit_addr", 32'(commit_addr), 32'(s.hd));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!(commit_valid && commit_ready)) begin
          chk("commit_fire", 32'(commit_valid && commit_ready), 1);
        end else begin
          chk("c_addr", 32'(commit_addr), 32'(e.addr));
          chk("c_value", commit_value, e.val);
          chk("c_dest", commit_dest, e.dest);
          chk("c_pold", 32'(commit_phyreg_old), 32'(e.pold));
          chk("c_load", 32'(commit_load), 32'(e.ld));
          chk("c_store", 32'(commit_store), 32'(e.st));
          chk("c_f3", 32'(commit_ldst_funct3), 32'(e.f3));
        end
      end else if (commit_valid && commit_ready) begin
        chk("commit_unexpected", 32'(commit_valid && commit_ready), 0);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #3;
    rst_chk("por");
    rst_n = 1'b1;

    repeat (10) cycle(100, 0, 0, 0, -1);
    rst_mid();

    repeat (3) cycle(100, 0, 0, 0, -1);
    cycle(0, 0, 100, 0, 2);
    cycle(0, 0, 100, 0, 0);
    cycle(0, 0, 100, 0, 1);
    repeat (4) cycle(0, 0, 100, 0, -1);

    repeat (5) cycle(100, 0, 0, 0, -1);
    cycle(0, 0, 100, 100, 0);
    repeat (3) cycle(0, 0, 100, 0, -1);

    repeat (300) cycle(60, 50, 70, 0, -1);
    repeat (300) cycle(60, 50, 70, 5, -1);
    repeat (40) cycle(100, 90, 100, 0, -1);
    repeat (40) cycle(70, 60, 20, 3, -1);
    rst_mid();
    repeat (200) cycle(60, 50, 70, 4, -1);
    repeat (30) cycle(0, 100, 100, 0, -1);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qu_rob.md
# qu_rob

Reorder buffer for the Qu out-of-order core. It sits between dispatch/rename, which allocates entries, and the retire/store path, which consumes committed entries. Execution units write results back into it by ROB address. The buffer is a circular queue of `rob_cell_t` entries that commits strictly in program order. It releases the old physical register on commit and converts a committed mispredicted branch into a one-cycle pipeline flush.

## Interface
Parameters:
- `DEPTH`, default `ROB_DEPTH` (8): number of entries; must be a power of two.
- `AW`, default `ROB_ADDR_WIDTH` (3): entry index width.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `alloc_valid`, in, 1: dispatch requests a new entry.
- `alloc_ready`, out, 1: an entry is free (`!full`).
- `alloc_addr`, out, AW: index the request will take (current tail).
- `alloc_phyreg_old`, in, 7: previous physical mapping of rd.
- `alloc_dest`, in, 32 (`dest_t`): physical rd, or 0 for stores.
- `alloc_load` / `alloc_store`, in, 1 each: memory op type.
- `alloc_ldst_funct3`, in, 3: load/store width code.
- `issue_valid`, in, 1: reservation station has issued an entry.
- `issue_addr`, in, AW: index of the issued entry.
- `wb_valid`, in, 1: result broadcast.
- `wb_addr`, in, AW: index being written back.
- `wb_value`, in, 32: result value, or store data.
- `wb_dest`, in, 32: store address (used only if the entry is a store).
- `wb_mispredicted`, in, 1: the branch was mispredicted.
- `wb_pc_new`, in, 12: corrected PC.
- `commit_valid`, out, 1: head entry is in RETIRED state.
- `commit_ready`, in, 1: retire stage accepts the head.
- `commit_value`, out, 32: head entry field.
- `commit_dest`, out, 32: head entry field.
- `commit_phyreg_old`, out, 7: head entry field.
- `commit_load`, `commit_store`, out, 1 each: head entry fields.
- `commit_ldst_funct3`, out, 3: head entry field.
- `commit_addr`, out, AW: head index.
- `flush`, out, 1: registered one-cycle pulse.
- `flush_pc`, out, 12: registered redirect target.
- `empty`, `full`, out, 1 each: occupancy flags.
- `count`, out, AW+1: number of occupied entries.

## Operation
- Storage: `DEPTH` × `rob_cell_t`. Pointers `head` and `tail` are AW bits wide and wrap modulo DEPTH. `count` is 0..DEPTH.
- Per-entry state machine, using the package encodings:
  - EMPTY → PENDING on alloc.
  - PENDING → EXECUTE on issue.
  - PENDING or EXECUTE → RETIRED on wb.
  - RETIRED → EMPTY on commit.
  - Any state → EMPTY on flush.
  - issue or wb aimed at an entry in any other state is ignored.
- Alloc fires when `alloc_valid && alloc_ready`:
  - the entry at `tail` is loaded with the alloc fields; `value` and `mispredicted_branch` are cleared;
  - `tail` increments.
- Writeback writes `value` and `mispredicted_branch`. It also writes `pc_new`, and writes `dest` only when the entry has `store=1`.
- Commit fires when `commit_valid && commit_ready`:
  - the head entry goes to EMPTY and `head` increments;
  - `commit_*` outputs are a combinational view of the head entry.
- Flush: a commit of an entry with `mispredicted_branch=1` on edge N does all of the following on that edge:
  - clears every entry to EMPTY;
  - sets `head=tail=0` and `count=0`;
  - registers `flush=1` and `flush_pc=pc_new` for cycle N+1 only.
  - The committed branch itself still presents its commit fields in its commit cycle.
- `count` next = `count` + alloc − commit, forced to 0 on flush.
- `full` = (`count`==DEPTH); `empty` = (`count`==0).

## Timing
- Reset values:
  - all entries EMPTY; `head=tail=0`; `count=0`;
  - `empty=1`, `full=0`, `alloc_ready=1`, `alloc_addr=0`;
  - `commit_valid=0`, `commit_addr=0`, all `commit_*` data 0;
  - `flush=0`, `flush_pc=0`.
  - Reset asserted mid-operation discards all contents immediately (asynchronous).
- Alloc → visible in state: next cycle.
- wb → `commit_valid`: next cycle, i.e. minimum 1-cycle latency from writeback to commit.
- wb and commit in the same cycle on the head entry: commit sees the pre-edge state and fires one cycle later.
- `alloc_ready` depends only on `full`; it does not anticipate a same-cycle commit.
- Simultaneous alloc and commit: both take effect and `count` is unchanged.
- Alloc in a flush-causing commit cycle is discarded.
- Issue and wb to the same address in one cycle: wb wins and the entry goes to RETIRED.
- Wrap: after index DEPTH−1 the pointers return to 0.

## Test plan
- **Reset, then fill:** 8 allocs with wb withheld → `alloc_addr` 0..7, then `full=1`, `alloc_ready=0`, `count=8`; a 9th `alloc_valid` is ignored.
- **Out-of-order wb, in-order commit:** alloc 3 entries; wb to addr 2, 0, 1 (values 0x22, 0x00, 0x11); `commit_ready=1` → commits in order 0, 1, 2 with those values; `commit_valid` first rises the cycle after the addr-0 wb.
- **Store:** alloc with `store=1`, `funct3=SW`; wb `value=0xDEAD`, `dest=0x40` → commit shows `commit_store=1`, `dest=0x40`, `value=0xDEAD`.
- **Mispredict:** alloc 5; wb addr 0 with `mispredicted=1`, `pc_new=0x123`; commit → next cycle `flush=1`, `flush_pc=0x123`, `empty=1`, `alloc_addr=0`; `flush=0` the cycle after.
- **Wrap and simultaneous events:** steady alloc+commit for 20 cycles → `count` stays constant and pointers wrap 7→0 correctly.
- **Backpressure and reset:** with `commit_ready=0` the head holds; `rst_n` pulsed low mid-stream → all outputs return to their reset values asynchronously.
